montgomery_exp: RTL and testbench
=================================

MONTGOMERY_EXP -- requirements
Module: montgomery_exp

Interface
REQ-001 Parameter WIDTH, default 1024: operand, modulus and exponent width.
REQ-002 Parameter ELEN_W, default 11: width of exponent-length input (holds 0..WIDTH).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request; samples all in_* operands.
REQ-006 in_x  input  WIDTH  base in Montgomery domain (x*R mod m).
REQ-007 in_r  input  WIDTH  R mod m (Montgomery one).
REQ-008 in_e  input  WIDTH  exponent; bits [in_e_len-1:0] used.
REQ-009 in_e_len  input  ELEN_W  exponent bit length t, 0..WIDTH.
REQ-010 in_m  input  WIDTH  odd modulus.
REQ-011 result  output  WIDTH  x^e mod m, normal domain.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 busy  output  1  high from accepted start until done cycle inclusive.
REQ-014 mul_start  output  1  one-cycle pulse to downstream montgomery multiplier.
REQ-015 mul_a, mul_b, mul_m  output  WIDTH each  multiplier operands, stable from mul_start until mul_done.
REQ-016 mul_result  input  WIDTH  multiplier output.
REQ-017 mul_done  input  1  multiplier completion, sampled only in wait states.

Function
REQ-018 Algorithm left-to-right square-and-multiply: A=in_r; for i=t-1 downto 0: A=A*A; if e[i]: A=A*X; finally A=A*1 (leave Montgomery domain).
REQ-019 Multiplication count SHALL be t + popcount(e[t-1:0]) + 1.
REQ-020 States: IDLE, SQ, SQ_WAIT, MUL, MUL_WAIT, POST, POST_WAIT, FIN.
REQ-021 IDLE: start=1 latches X, E, t, M; A=in_r; bit index i=t-1; next SQ if t>0, else POST.
REQ-022 SQ: mul_start=1, mul_a=mul_b=A; next SQ_WAIT.
REQ-023 SQ_WAIT: on mul_done A=mul_result; next MUL if E[i]=1, else (i=0 ? POST : SQ with i-1).
REQ-024 MUL: mul_start=1, mul_a=A, mul_b=X; next MUL_WAIT.
REQ-025 MUL_WAIT: on mul_done A=mul_result; next i=0 ? POST : SQ with i-1.
REQ-026 POST: mul_start=1, mul_a=A, mul_b=1; next POST_WAIT; on mul_done result=mul_result, next FIN.
REQ-027 FIN: done=1 for exactly one cycle; next IDLE.
REQ-028 mul_m SHALL equal latched M whenever busy.
REQ-029 Latency: mul_start cycle after start acceptance and cycle after each mul_done; done cycle after final mul_done.
REQ-030 start while busy SHALL be ignored; operands unchanged.
REQ-031 mul_done outside *_WAIT states SHALL be ignored.
REQ-032 mul_done coincident with mul_start cycle SHALL be ignored (wait state begins next cycle).
REQ-033 result SHALL hold until next POST_WAIT capture.
REQ-034 Bits of in_e at or above t SHALL not affect result.

Reset
REQ-035 resetn=0 at any time, including mid-operation: state=IDLE, result=0, done=0, busy=0, mul_start=0, all internal registers 0.
REQ-036 After resetn release, first cycle SHALL be IDLE accepting start.

Structure
REQ-037 Shared package holds WIDTH, ELEN_W defaults and state enumeration.
REQ-038 No sub-module inside; the montgomery multiplier is instantiated beside it at the top level, wired via mul_* ports.
REQ-039 Exponent scanned by index counter, not shift of a WIDTH copy.

Verification (bench: stub multiplier returning (a*b) mod m after 5 cycles; in_r=1)
REQ-040 x=3, e=0xB, t=4, m=1000 -> result=147, exactly 8 mul_start pulses, one done pulse.
REQ-041 t=0, x=5, m=1000 -> result=1, exactly 1 mul_start (mul_b=1).
REQ-042 x=2, e=0xFFF1 (upper bits), t=4, m=1000 -> result=2, 6 mul_starts.
REQ-043 start pulsed mid-run with different operands -> ignored, first result unchanged.
REQ-044 resetn low during MUL_WAIT -> all outputs 0 next cycle; new run x=7,e=2,t=2,m=10 -> result=9.
REQ-045 Stray mul_done in IDLE and in the mul_start cycle -> no state change, count unchanged.

Source files
------------

// File: rtl/montgomery_exp_pkg.sv
// rtl/montgomery_exp_pkg.sv - shared widths and FSM state encoding for montgomery_exp
package montgomery_exp_pkg;

    localparam int DEFAULT_WIDTH  = 1024;
    localparam int DEFAULT_ELEN_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SQ        = 3'd1,
        ST_SQ_WAIT   = 3'd2,
        ST_MUL       = 3'd3,
        ST_MUL_WAIT  = 3'd4,
        ST_POST      = 3'd5,
        ST_POST_WAIT = 3'd6,
        ST_FIN       = 3'd7
    } state_e;

endpackage

// File: rtl/montgomery_exp_if.sv
// rtl/montgomery_exp_if.sv - request/result and external multiplier handshake bundle
interface montgomery_exp_if #(
    parameter int WIDTH  = montgomery_exp_pkg::DEFAULT_WIDTH,
    parameter int ELEN_W = montgomery_exp_pkg::DEFAULT_ELEN_W
);

    logic              start;
    logic [WIDTH-1:0]  in_x;
    logic [WIDTH-1:0]  in_r;
    logic [WIDTH-1:0]  in_e;
    logic [ELEN_W-1:0] in_e_len;
    logic [WIDTH-1:0]  in_m;
    logic [WIDTH-1:0]  result;
    logic              done;
    logic              busy;
    logic              mul_start;
    logic [WIDTH-1:0]  mul_a;
    logic [WIDTH-1:0]  mul_b;
    logic [WIDTH-1:0]  mul_m;
    logic [WIDTH-1:0]  mul_result;
    logic              mul_done;

    modport slave (
        input  start, in_x, in_r, in_e, in_e_len, in_m, mul_result, mul_done,
        output result, done, busy, mul_start, mul_a, mul_b, mul_m
    );

    modport master (
        output start, in_x, in_r, in_e, in_e_len, in_m, mul_result, mul_done,
        input  result, done, busy, mul_start, mul_a, mul_b, mul_m
    );

endinterface

// File: rtl/montgomery_exp.sv
// rtl/montgomery_exp.sv - left-to-right square-and-multiply modular exponentiation sequencer
// driving an external Montgomery multiplier through the mul_* handshake.
module montgomery_exp
    import montgomery_exp_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ELEN_W = DEFAULT_ELEN_W
) (
    input  logic             clk,
    input  logic             resetn,
    montgomery_exp_if.slave  bus
);

    localparam int               IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  e_q, e_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [ELEN_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              mul_start_q, mul_start_d;
    logic              e_bit;
    logic              last_bit;

    // The running accumulator A lives in mul_a_q: every product is immediately
    // reissued as the next multiplier operand, so no separate copy is kept.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        e_d         = e_q;
        m_d         = m_q;
        result_d    = result_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        mul_start_d = 1'b0;
        e_bit       = e_q[idx_q[IDX_W-1:0]];
        last_bit    = (idx_q == '0);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x_d         = bus.in_x;
                    e_d         = bus.in_e;
                    m_d         = bus.in_m;
                    busy_d      = 1'b1;
                    mul_start_d = 1'b1;
                    mul_a_d     = bus.in_r;
                    if (bus.in_e_len != '0) begin
                        idx_d   = bus.in_e_len - ELEN_W'(1);
                        mul_b_d = bus.in_r;
                        state_d = ST_SQ;
                    end else begin
                        idx_d   = '0;
                        mul_b_d = ONE;
                        state_d = ST_POST;
                    end
                end
            end

            ST_SQ:   state_d = ST_SQ_WAIT;
            ST_MUL:  state_d = ST_MUL_WAIT;
            ST_POST: state_d = ST_POST_WAIT;

            ST_SQ_WAIT: begin
                if (bus.mul_done) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = bus.mul_result;
                    if (e_bit) begin
                        mul_b_d = x_q;
                        state_d = ST_MUL;
                    end else if (last_bit) begin
                        mul_b_d = ONE;
                        state_d = ST_POST;
                    end else begin
                        mul_b_d = bus.mul_result;
                        idx_d   = idx_q - ELEN_W'(1);
                        state_d = ST_SQ;
                    end
                end
            end

            ST_MUL_WAIT: begin
                if (bus.mul_done) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = bus.mul_result;
                    if (last_bit) begin
                        mul_b_d = ONE;
                        state_d = ST_POST;
                    end else begin
                        mul_b_d = bus.mul_result;
                        idx_d   = idx_q - ELEN_W'(1);
                        state_d = ST_SQ;
                    end
                end
            end

            ST_POST_WAIT: begin
                if (bus.mul_done) begin
                    result_d = bus.mul_result;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            e_q         <= '0;
            m_q         <= '0;
            result_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            e_q         <= e_d;
            m_q         <= m_d;
            result_q    <= result_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_m     = m_q;

endmodule

// File: tb/tb_montgomery_exp.sv
// tb/tb_montgomery_exp.sv - scoreboard bench for montgomery_exp with a 5-cycle modmul stub
module tb_montgomery_exp;

    localparam int W  = 32;
    localparam int EW = 6;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    montgomery_exp_if #(.WIDTH(W), .ELEN_W(EW)) ifc ();

    montgomery_exp #(.WIDTH(W), .ELEN_W(EW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    int           mul_cnt  = 0;
    int           done_cnt = 0;
    int           pend     = 0;
    logic [W-1:0] pend_res;
    logic [W-1:0] last_mul_b;
    logic [W-1:0] cur_m    = '0;
    bit           stray_mode = 1'b0;
    bit           idle_stray = 1'b0;
    logic [W-1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [W-1:0] ref_exp(input logic [W-1:0] x, input logic [W-1:0] e,
                                             input int t, input logic [W-1:0] m);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = t - 1; i >= 0; i--) begin
            acc = (acc * acc) % {32'd0, m};
            if (e[i]) acc = (acc * {32'd0, x}) % {32'd0, m};
        end
        return acc[W-1:0] % m;
    endfunction

    function automatic int ref_muls(input logic [W-1:0] e, input int t);
        int n;
        n = t + 1;
        for (int i = 0; i < t; i++) if (e[i]) n++;
        return n;
    endfunction

    // Multiplier stub: plain (a*b) mod m, answered 5 cycles after mul_start.
    initial begin
        ifc.mul_done   = 1'b0;
        ifc.mul_result = '0;
        forever begin
            @(posedge clk); #1;
            ifc.mul_done = 1'b0;
            if (!resetn) begin
                pend = 0;
            end else if (idle_stray) begin
                idle_stray     = 1'b0;
                ifc.mul_done   = 1'b1;
                ifc.mul_result = 32'hDEAD_BEEF;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ifc.mul_done   = 1'b1;
                    ifc.mul_result = pend_res;
                end
            end else if (ifc.mul_start) begin
                mul_cnt++;
                last_mul_b = ifc.mul_b;
                check("mul_m", ifc.mul_m, cur_m);
                pend_res = 32'(({32'd0, ifc.mul_a} * {32'd0, ifc.mul_b}) % {32'd0, ifc.mul_m});
                pend     = 5;
                if (stray_mode) begin
                    ifc.mul_done   = 1'b1;
                    ifc.mul_result = 32'h1234_5678;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ifc.done) begin
                done_cnt++;
                check("busy_at_done", ifc.busy, 1);
                if (sb_q.size() == 0) check("sb_underflow", 1, 0);
                else check("result", ifc.result, sb_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] e, input int t,
                          input logic [W-1:0] m, input bit pulse_mid);
        int           m0, d0, n, exp_n;
        logic [W-1:0] exp_r;
        exp_r = ref_exp(x, e, t, m);
        exp_n = ref_muls(e, t);
        m0 = mul_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        cur_m        = m;
        ifc.start    = 1'b1;
        ifc.in_x     = x;
        ifc.in_e     = e;
        ifc.in_e_len = EW'(t);
        ifc.in_m     = m;
        ifc.in_r     = 32'd1;
        sb_q.push_back(exp_r);
        @(posedge clk); #1;
        ifc.start    = 1'b0;
        ifc.in_x     = ~x;
        ifc.in_e     = ~e;
        ifc.in_m     = m + 32'd2;
        ifc.in_r     = 32'd7;
        check("busy_after_start", ifc.busy, 1);
        if (pulse_mid) begin
            repeat (10) @(posedge clk);
            #1;
            ifc.start    = 1'b1;
            ifc.in_x     = 32'd9;
            ifc.in_e     = 32'd3;
            ifc.in_e_len = EW'(2);
            ifc.in_m     = 32'd999;
            @(posedge clk); #1;
            ifc.start    = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("mul_count", mul_cnt - m0, exp_n);
        check("done_pulses", done_cnt - d0, 1);
        check("busy_idle", ifc.busy, 0);
        check("result_hold", ifc.result, exp_r);
    endtask

    initial begin
        int           m0, d0, n;
        logic [W-1:0] rm, rx, re;
        int           rt;
        ifc.start    = 1'b0;
        ifc.in_x     = '0;
        ifc.in_r     = '0;
        ifc.in_e     = '0;
        ifc.in_e_len = '0;
        ifc.in_m     = '0;

        @(negedge clk);
        check("rst_result", ifc.result, 0);
        check("rst_done", ifc.done, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_mul_start", ifc.mul_start, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op(32'd3, 32'hB, 4, 32'd1000, 1'b0);
        run_op(32'd5, 32'h0, 0, 32'd1000, 1'b0);
        check("t0_mul_b", last_mul_b, 1);
        run_op(32'd2, 32'hFFF1, 4, 32'd1000, 1'b0);
        run_op(32'd3, 32'hB, 4, 32'd1000, 1'b1);

        m0 = mul_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        idle_stray = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_stray_busy", ifc.busy, 0);
        check("idle_stray_muls", mul_cnt - m0, 0);
        check("idle_stray_done", done_cnt - d0, 0);
        check("idle_stray_result", ifc.result, 147);

        stray_mode = 1'b1;
        run_op(32'd3, 32'h5, 3, 32'd1000, 1'b0);
        stray_mode = 1'b0;

        m0 = mul_cnt;
        @(posedge clk); #1;
        cur_m        = 32'd1000;
        ifc.start    = 1'b1;
        ifc.in_x     = 32'd5;
        ifc.in_e     = 32'hB;
        ifc.in_e_len = EW'(4);
        ifc.in_m     = 32'd1000;
        ifc.in_r     = 32'd1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        n = 0;
        while (mul_cnt < m0 + 2 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (mul_cnt < m0 + 2) check("mul_wait_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("midrst_result", ifc.result, 0);
        check("midrst_busy", ifc.busy, 0);
        check("midrst_done", ifc.done, 0);
        check("midrst_mul_start", ifc.mul_start, 0);
        check("midrst_mul_m", ifc.mul_m, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        run_op(32'd7, 32'h2, 2, 32'd10, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rm = 32'($urandom_range(3, 65535)) | 32'd1;
            rx = 32'($urandom_range(0, 65535)) % rm;
            re = 32'($urandom);
            rt = $urandom_range(0, 16);
            run_op(rx, re, rt, rm, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
